splitting_4kb_merger: RTL and testbench

Response-side companion to the 4 KB burst splitter in the AXI interconnect. For every original AW/AR the splitter forwards, it records whether the burst was split in two at a 4 KB boundary. This block then turns the slave's responses back into one response per original transaction: it absorbs the first B of a split write, and it suppresses the intermediate RLAST of a split read. It sits between the slave-side B/R channels and the master-side B/R channels.

---
 rtl/splitting_4kb_merger_pkg.sv | 25 ++
 rtl/splitting_4kb_merger_if.sv | 56 +++++
 rtl/splitting_info_fifo.sv | 51 +++++
 rtl/splitting_4kb_merger.sv | 144 ++++++++++++++
 tb/tb_splitting_4kb_merger.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/splitting_4kb_merger_pkg.sv
// Shared definitions for the 4 KB splitter response merger.
//   - AXI RESP encodings, ordered so numeric max gives the most severe response
//   - B-channel FSM state encoding
//   - resp_merge(): combines the two halves of a split write response
package splitting_4kb_merger_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } axi_resp_e;

    typedef enum logic [1:0] {
        B_IDLE   = 2'd0,
        B_FIRST  = 2'd1,
        B_SECOND = 2'd2
    } b_state_e;

    // DECERR > SLVERR > EXOKAY > OKAY, so the encodings compare numerically.
    function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/splitting_4kb_merger_if.sv
// Bundle of the merger's info, B and R channels.
//   slave  : merger side (consumes info + slave responses, produces master responses)
//   master : environment side (splitter, slave port and master port drivers)
// Signal names keep the _i/_o suffixes as seen from the merger.
interface splitting_4kb_merger_if #(
    parameter int ID_WIDTH   = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  AW_info_valid_i;
    logic                  AW_info_crossing_i;
    logic                  AW_info_ready_o;
    logic                  AR_info_valid_i;
    logic                  AR_info_crossing_i;
    logic                  AR_info_ready_o;

    logic [ID_WIDTH-1:0]   sB_ID_i;
    logic [1:0]            sB_RESP_i;
    logic                  sB_VALID_i;
    logic                  sB_READY_o;
    logic [ID_WIDTH-1:0]   mB_ID_o;
    logic [1:0]            mB_RESP_o;
    logic                  mB_VALID_o;
    logic                  mB_READY_i;

    logic [ID_WIDTH-1:0]   sR_ID_i;
    logic [DATA_WIDTH-1:0] sR_DATA_i;
    logic [1:0]            sR_RESP_i;
    logic                  sR_LAST_i;
    logic                  sR_VALID_i;
    logic                  sR_READY_o;
    logic [ID_WIDTH-1:0]   mR_ID_o;
    logic [DATA_WIDTH-1:0] mR_DATA_o;
    logic [1:0]            mR_RESP_o;
    logic                  mR_LAST_o;
    logic                  mR_VALID_o;
    logic                  mR_READY_i;

    modport slave (
        input  AW_info_valid_i, AW_info_crossing_i, AR_info_valid_i, AR_info_crossing_i,
        output AW_info_ready_o, AR_info_ready_o,
        input  sB_ID_i, sB_RESP_i, sB_VALID_i, mB_READY_i,
        output sB_READY_o, mB_ID_o, mB_RESP_o, mB_VALID_o,
        input  sR_ID_i, sR_DATA_i, sR_RESP_i, sR_LAST_i, sR_VALID_i, mR_READY_i,
        output sR_READY_o, mR_ID_o, mR_DATA_o, mR_RESP_o, mR_LAST_o, mR_VALID_o
    );

    modport master (
        output AW_info_valid_i, AW_info_crossing_i, AR_info_valid_i, AR_info_crossing_i,
        input  AW_info_ready_o, AR_info_ready_o,
        output sB_ID_i, sB_RESP_i, sB_VALID_i, mB_READY_i,
        input  sB_READY_o, mB_ID_o, mB_RESP_o, mB_VALID_o,
        output sR_ID_i, sR_DATA_i, sR_RESP_i, sR_LAST_i, sR_VALID_i, mR_READY_i,
        input  sR_READY_o, mR_ID_o, mR_DATA_o, mR_RESP_o, mR_LAST_o, mR_VALID_o
    );

endinterface

// File: rtl/splitting_info_fifo.sv
// 1-bit synchronous FIFO holding one "was split" flag per outstanding transaction.
//   clk, rst            : clock, async active-high reset
//   push, push_data     : write request / flag (ignored while full, even if popping)
//   pop                 : read request (ignored while empty)
//   head                : flag at the read pointer, visible the cycle after its push
//   full, empty         : occupancy flags
module splitting_info_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic push_data,
    input  logic pop,
    output logic head,
    output logic full,
    output logic empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = 1;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic [DEPTH-1:0] mem;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            mem    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[PW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/splitting_4kb_merger.sv
// Merges the responses of bursts split at a 4 KB boundary back into one
// response per original transaction.
//   ACLK_i, ARESET_i : clock, async active-high reset
//   bus (slave)      : AW/AR info from the splitter, slave-side B/R in,
//                      master-side B/R out
//
// B FSM
//   state    | meaning
//   B_IDLE   | no split in progress; unsplit head passes straight through
//   B_FIRST  | head is split; absorbing its first slave B
//   B_SECOND | first B captured in resp_acc; passing second B with merged RESP
module splitting_4kb_merger
    import splitting_4kb_merger_pkg::*;
#(
    parameter int ID_WIDTH   = 5,
    parameter int DATA_WIDTH = 32,
    parameter int INFO_DEPTH = 4
) (
    input  logic                  ACLK_i,
    input  logic                  ARESET_i,
    splitting_4kb_merger_if.slave bus
);

    logic                  w_head, w_full, w_empty, w_pop;
    logic                  r_head, r_full, r_empty, r_pop;

    b_state_e              b_state;
    logic [1:0]            resp_acc;
    logic                  r_seg;

    logic [ID_WIDTH-1:0]   b_id;
    logic [ID_WIDTH-1:0]   r_id;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  sb_ready, mb_valid;
    logic [1:0]            mb_resp;
    logic                  r_mid, r_last_fire;

    splitting_info_fifo #(.DEPTH(INFO_DEPTH)) u_aw_info (
        .clk       (ACLK_i),
        .rst       (ARESET_i),
        .push      (bus.AW_info_valid_i),
        .push_data (bus.AW_info_crossing_i),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    splitting_info_fifo #(.DEPTH(INFO_DEPTH)) u_ar_info (
        .clk       (ACLK_i),
        .rst       (ARESET_i),
        .push      (bus.AR_info_valid_i),
        .push_data (bus.AR_info_crossing_i),
        .pop       (r_pop),
        .head      (r_head),
        .full      (r_full),
        .empty     (r_empty)
    );

    assign bus.AW_info_ready_o = ~w_full;
    assign bus.AR_info_ready_o = ~r_full;

    // ---------------- B channel ----------------
    always_comb begin
        sb_ready = 1'b0;
        mb_valid = 1'b0;
        mb_resp  = bus.sB_RESP_i;
        w_pop    = 1'b0;
        case (b_state)
            B_IDLE: begin
                // A split head waits one cycle for B_FIRST, so only unsplit heads pass here.
                if (!w_empty && !w_head) begin
                    mb_valid = bus.sB_VALID_i;
                    sb_ready = bus.mB_READY_i;
                    w_pop    = bus.sB_VALID_i & bus.mB_READY_i;
                end
            end
            B_FIRST: begin
                sb_ready = 1'b1;
            end
            B_SECOND: begin
                mb_valid = bus.sB_VALID_i;
                sb_ready = bus.mB_READY_i;
                mb_resp  = resp_merge(resp_acc, bus.sB_RESP_i);
                w_pop    = bus.sB_VALID_i & bus.mB_READY_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge ACLK_i or posedge ARESET_i) begin
        if (ARESET_i) begin
            b_state  <= B_IDLE;
            resp_acc <= RESP_OKAY;
        end else begin
            case (b_state)
                B_IDLE: begin
                    if (!w_empty && w_head) b_state <= B_FIRST;
                end
                B_FIRST: begin
                    if (bus.sB_VALID_i) begin
                        resp_acc <= bus.sB_RESP_i;
                        b_state  <= B_SECOND;
                    end
                end
                B_SECOND: begin
                    if (bus.sB_VALID_i && bus.mB_READY_i) b_state <= B_IDLE;
                end
                default: b_state <= B_IDLE;
            endcase
        end
    end

    assign b_id           = bus.sB_ID_i;
    assign bus.mB_ID_o    = b_id;
    assign bus.mB_RESP_o  = mb_resp;
    assign bus.mB_VALID_o = mb_valid;
    assign bus.sB_READY_o = sb_ready;

    // ---------------- R channel ----------------
    // r_mid: the current beat belongs to the first half of a split read, so
    // its LAST marks only the end of that half.
    assign r_mid       = r_head & ~r_seg;
    assign r_last_fire = bus.sR_VALID_i & bus.sR_READY_o & bus.sR_LAST_i;
    assign r_pop       = r_last_fire & ~r_mid;

    always_ff @(posedge ACLK_i or posedge ARESET_i) begin
        if (ARESET_i) begin
            r_seg <= 1'b0;
        end else if (r_last_fire) begin
            r_seg <= r_mid;
        end
    end

    assign r_id           = bus.sR_ID_i;
    assign r_data         = bus.sR_DATA_i;
    assign bus.mR_ID_o    = r_id;
    assign bus.mR_DATA_o  = r_data;
    assign bus.mR_RESP_o  = bus.sR_RESP_i;
    assign bus.mR_LAST_o  = bus.sR_LAST_i & ~r_mid;
    assign bus.mR_VALID_o = bus.sR_VALID_i & ~r_empty;
    assign bus.sR_READY_o = bus.mR_READY_i & ~r_empty;

endmodule

// File: tb/tb_splitting_4kb_merger.sv
module tb_splitting_4kb_merger;

    localparam int NT = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    splitting_4kb_merger_if #(.ID_WIDTH(5), .DATA_WIDTH(32)) bus ();

    splitting_4kb_merger #(.ID_WIDTH(5), .DATA_WIDTH(32), .INFO_DEPTH(4)) dut (
        .ACLK_i   (clk),
        .ARESET_i (rst),
        .bus      (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.AW_info_valid_i = 0; bus.AW_info_crossing_i = 0;
        bus.AR_info_valid_i = 0; bus.AR_info_crossing_i = 0;
        bus.sB_ID_i = 0; bus.sB_RESP_i = 0; bus.sB_VALID_i = 0; bus.mB_READY_i = 0;
        bus.sR_ID_i = 0; bus.sR_DATA_i = 0; bus.sR_RESP_i = 0; bus.sR_LAST_i = 0;
        bus.sR_VALID_i = 0; bus.mR_READY_i = 0;
    endtask

    // Positioned just after a negedge; waits (bounded) until the merger accepts the slave B.
    task automatic wait_sb_ready(input string tag);
        int n = 0;
        while (!bus.sB_READY_o && n < 10) begin
            tick();
            @(negedge clk);
            n++;
        end
        check_val(tag, bus.sB_READY_o, 1);
    endtask

    task automatic push_aw(input logic crossing);
        tick();
        bus.AW_info_valid_i = 1; bus.AW_info_crossing_i = crossing;
        tick();
        bus.AW_info_valid_i = 0;
    endtask

    // ---------------- reference model data ----------------
    typedef struct {
        logic [4:0] id;
        logic [1:0] resp;
        int         txn;
        bit         first_of_split;
    } b_beat_t;

    typedef struct {
        logic [4:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        bit          slast;  // LAST as the slave sends it
        bit          mlast;  // LAST the master must see
        int          txn;
    } r_beat_t;

    bit      w_info[$];
    bit      r_info[$];
    b_beat_t sb_q[$];
    logic [6:0] mb_exp[$];   // {id, resp} of each merged master B
    r_beat_t r_q[$];

    task automatic gen_random();
        for (int i = 0; i < NT; i++) begin
            bit         cw = 1'($urandom_range(0, 1));
            logic [4:0] id = 5'($urandom);
            logic [1:0] r0 = 2'($urandom);
            logic [1:0] r1 = 2'($urandom);
            bit         cr = 1'($urandom_range(0, 1));
            logic [4:0] rid = 5'($urandom);
            int         nseg;
            w_info.push_back(cw);
            if (cw) begin
                sb_q.push_back('{id, r0, i, 1'b1});
                sb_q.push_back('{id, r1, i, 1'b0});
                mb_exp.push_back({id, (r0 > r1) ? r0 : r1});
            end else begin
                sb_q.push_back('{id, r0, i, 1'b0});
                mb_exp.push_back({id, r0});
            end
            r_info.push_back(cr);
            nseg = cr ? 2 : 1;
            for (int s = 0; s < nseg; s++) begin
                int len = $urandom_range(1, 3);
                for (int b = 0; b < len; b++) begin
                    r_beat_t e;
                    e.id    = rid;
                    e.data  = $urandom;
                    e.resp  = 2'($urandom);
                    e.slast = (b == len - 1);
                    e.mlast = (b == len - 1) && (s == nseg - 1);
                    e.txn   = i;
                    r_q.push_back(e);
                end
            end
        end
    endtask

    initial begin : main
        int cnt;
        int w_pushed, w_done, sb_idx, mb_idx;
        int r_pushed, r_done, sr_idx, mr_idx;
        bit sb_vld, sr_vld;
        bit aw_fire, ar_fire, sb_fire, mb_fire, sr_fire, mr_fire;

        // ---- reset state, stalled slave responses with empty info ----
        idle_inputs();
        bus.sB_VALID_i = 1; bus.sB_ID_i = 5'd3; bus.mB_READY_i = 1;
        bus.sR_VALID_i = 1; bus.sR_LAST_i = 1; bus.mR_READY_i = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check_val("rst_ready_info", {bus.AW_info_ready_o, bus.AR_info_ready_o}, 2'b11);
        check_val("rst_valids", {bus.mB_VALID_o, bus.mR_VALID_o}, 2'b00);
        check_val("rst_slave_ready", {bus.sB_READY_o, bus.sR_READY_o}, 2'b00);
        check_val("rst_follow", {bus.mB_ID_o, bus.mR_LAST_o}, {5'd3, 1'b1});
        tick();
        idle_inputs();

        // ---- fill AW info, then push refused during a pop ----
        bus.AW_info_valid_i = 1; bus.AW_info_crossing_i = 0;
        repeat (4) @(posedge clk);
        #1;
        bus.sB_VALID_i = 1; bus.sB_ID_i = 5'd7; bus.sB_RESP_i = 2'd1; bus.mB_READY_i = 1;
        @(negedge clk);
        check_val("full_ready", bus.AW_info_ready_o, 0);
        check_val("full_pass", {bus.mB_VALID_o, bus.sB_READY_o, bus.mB_ID_o, bus.mB_RESP_o},
                  {1'b1, 1'b1, 5'd7, 2'd1});
        tick();
        bus.AW_info_valid_i = 0;
        @(negedge clk);
        check_val("after_pop_ready", bus.AW_info_ready_o, 1);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus.mB_VALID_o) cnt++;
            tick();
            @(negedge clk);
        end
        check_val("full_drain_cnt", cnt, 3);
        tick();
        idle_inputs();

        // ---- split write: absorb first B, hold merged B under back-pressure ----
        push_aw(1'b1);
        bus.sB_VALID_i = 1; bus.sB_ID_i = 5'd9; bus.sB_RESP_i = 2'd1; bus.mB_READY_i = 1;
        @(negedge clk);
        check_val("split_absorb", bus.mB_VALID_o, 0);
        wait_sb_ready("split_first_ready");
        tick();
        bus.sB_RESP_i = 2'd2; bus.mB_READY_i = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_val("hold_merged", {bus.mB_VALID_o, bus.mB_ID_o, bus.mB_RESP_o, bus.sB_READY_o},
                      {1'b1, 5'd9, 2'd2, 1'b0});
            tick();
        end
        bus.mB_READY_i = 1;
        @(negedge clk);
        check_val("merged_fire", {bus.mB_VALID_o, bus.sB_READY_o, bus.mB_RESP_o}, {1'b1, 1'b1, 2'd2});
        tick();
        @(negedge clk);
        check_val("merged_popped", {bus.mB_VALID_o, bus.sB_READY_o, bus.AW_info_ready_o}, 3'b001);
        tick();
        idle_inputs();

        // ---- async reset inside B_SECOND ----
        push_aw(1'b1);
        bus.sB_VALID_i = 1; bus.sB_ID_i = 5'd4; bus.sB_RESP_i = 2'd3; bus.mB_READY_i = 0;
        @(negedge clk);
        wait_sb_ready("rst2_first_ready");
        tick();
        bus.sB_RESP_i = 2'd0;
        @(negedge clk);
        check_val("second_merged", {bus.mB_VALID_o, bus.mB_RESP_o}, {1'b1, 2'd3});
        #1 rst = 1;
        #1;
        check_val("async_rst", {bus.mB_VALID_o, bus.sB_READY_o, bus.AW_info_ready_o}, 3'b001);
        tick();
        rst = 0;
        idle_inputs();
        push_aw(1'b0);
        bus.sB_VALID_i = 1; bus.sB_ID_i = 5'd5; bus.sB_RESP_i = 2'd1; bus.mB_READY_i = 1;
        @(negedge clk);
        check_val("post_rst_pass", {bus.mB_VALID_o, bus.mB_ID_o, bus.mB_RESP_o}, {1'b1, 5'd5, 2'd1});
        tick();
        @(negedge clk);
        check_val("post_rst_popped", bus.mB_VALID_o, 0);
        tick();
        idle_inputs();

        // ---- randomized traffic against the transaction-level model ----
        gen_random();
        w_pushed = 0; w_done = 0; sb_idx = 0; mb_idx = 0; sb_vld = 0;
        r_pushed = 0; r_done = 0; sr_idx = 0; mr_idx = 0; sr_vld = 0;
        for (int cyc = 0; cyc < 8000 && !(w_done == NT && r_done == NT); cyc++) begin
            tick();
            bus.AW_info_valid_i    = (w_pushed < NT) && ($urandom_range(0, 2) != 0);
            bus.AW_info_crossing_i = (w_pushed < NT) ? w_info[w_pushed] : 1'b0;
            bus.AR_info_valid_i    = (r_pushed < NT) && ($urandom_range(0, 2) != 0);
            bus.AR_info_crossing_i = (r_pushed < NT) ? r_info[r_pushed] : 1'b0;
            if (!sb_vld && sb_idx < sb_q.size() && sb_q[sb_idx].txn < w_pushed &&
                $urandom_range(0, 3) != 0) sb_vld = 1;
            bus.sB_VALID_i = sb_vld;
            if (sb_vld) begin
                bus.sB_ID_i = sb_q[sb_idx].id; bus.sB_RESP_i = sb_q[sb_idx].resp;
            end
            bus.mB_READY_i = ($urandom_range(0, 3) != 0);
            if (!sr_vld && sr_idx < r_q.size() && r_q[sr_idx].txn < r_pushed &&
                $urandom_range(0, 3) != 0) sr_vld = 1;
            bus.sR_VALID_i = sr_vld;
            if (sr_vld) begin
                bus.sR_ID_i   = r_q[sr_idx].id;   bus.sR_DATA_i = r_q[sr_idx].data;
                bus.sR_RESP_i = r_q[sr_idx].resp; bus.sR_LAST_i = r_q[sr_idx].slast;
            end
            bus.mR_READY_i = ($urandom_range(0, 3) != 0);

            @(negedge clk);
            aw_fire = bus.AW_info_valid_i & bus.AW_info_ready_o;
            ar_fire = bus.AR_info_valid_i & bus.AR_info_ready_o;
            sb_fire = bus.sB_VALID_i & bus.sB_READY_o;
            mb_fire = bus.mB_VALID_o & bus.mB_READY_i;
            sr_fire = bus.sR_VALID_i & bus.sR_READY_o;
            mr_fire = bus.mR_VALID_o & bus.mR_READY_i;

            check_val("aw_ready", bus.AW_info_ready_o, 64'((w_pushed - w_done) < 4));
            check_val("ar_ready", bus.AR_info_ready_o, 64'((r_pushed - r_done) < 4));
            if (sb_vld && sb_q[sb_idx].first_of_split)
                check_val("absorb_first", bus.mB_VALID_o, 0);
            if (mb_fire) begin
                if (mb_idx < mb_exp.size()) begin
                    check_val("mb_beat", {bus.mB_ID_o, bus.mB_RESP_o}, mb_exp[mb_idx]);
                    mb_idx++;
                end else begin
                    check_val("mb_extra", 1, 0);
                end
                w_done++;
            end
            check_val("r_handshake", sr_fire, mr_fire);
            if (mr_fire) begin
                if (mr_idx < r_q.size()) begin
                    check_val("mr_beat",
                              {bus.mR_ID_o, bus.mR_DATA_o, bus.mR_RESP_o, bus.mR_LAST_o},
                              {r_q[mr_idx].id, r_q[mr_idx].data, r_q[mr_idx].resp, r_q[mr_idx].mlast});
                    if (r_q[mr_idx].mlast) r_done++;
                    mr_idx++;
                end else begin
                    check_val("mr_extra", 1, 0);
                    r_done++;
                end
            end
            if (aw_fire) w_pushed++;
            if (ar_fire) r_pushed++;
            if (sb_fire) begin sb_idx++; sb_vld = 0; end
            if (sr_fire) begin sr_idx++; sr_vld = 0; end
        end
        check_val("w_all_done", w_done, NT);
        check_val("r_all_done", r_done, NT);
        check_val("sb_all_sent", sb_idx, sb_q.size());
        check_val("mr_all_seen", mr_idx, r_q.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
